// File: rtl/dual_pt_sram_pkg.sv
// Shared defaults, data/address types and the address range helper for dual_pt_sram.
package dual_pt_sram_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;
    localparam int DEPTH_DEF  = 2 ** ADDR_W_DEF;

    typedef logic [DATA_W_DEF-1:0] data_t;
    typedef logic [ADDR_W_DEF-1:0] addr_t;

    // True when an address selects a physically present word.
    function automatic logic addr_ok(input int unsigned addr, input int unsigned depth);
        if (addr < depth) begin
            return 1'b1;
        end else begin
            return 1'b0;
        end
    endfunction

endpackage

// File: rtl/dual_pt_sram_array.sv
// Word storage with write port and combinational read view; out-of-range reads return zero.
module dual_pt_sram_array
    import dual_pt_sram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic              wr_ok_s;
    logic              rd_ok_s;

    assign wr_ok_s = addr_ok(32'(waddr), unsigned'(DEPTH));
    assign rd_ok_s = addr_ok(32'(raddr), unsigned'(DEPTH));

    // Storage: asynchronously cleared, written only for in-range addresses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (we && wr_ok_s) begin
            mem_r[waddr[IDX_W-1:0]] <= wdata;
        end
    end

    // Read view of the currently stored word.
    always_comb begin
        rdata = '0;
        if (rd_ok_s) begin
            rdata = mem_r[raddr[IDX_W-1:0]];
        end else begin
            rdata = '0;
        end
    end

endmodule

// File: rtl/dual_pt_sram.sv
// Dual-port SRAM: independent write and registered read ports, one-cycle read latency.
// Optional macro DUAL_PT_SRAM_BYPASS_EN makes same-address collisions write-first.
module dual_pt_sram
    import dual_pt_sram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic [DATA_W-1:0] din,
    input  logic              wen,
    input  logic              ren,
    input  logic              clk,
    input  logic [ADDR_W-1:0] addrw,
    input  logic [ADDR_W-1:0] addrr,
    output logic [DATA_W-1:0] dout,
    input  logic              rst_n,
    output logic              dout_valid
);

    logic [DATA_W-1:0] arr_rdata_s;
    logic [DATA_W-1:0] dout_next_s;
    logic [DATA_W-1:0] dout_r;
    logic              dout_valid_r;
    logic              rd_ok_s;
    logic              wr_ok_s;
    logic              collide_s;

    dual_pt_sram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wen),
        .waddr (addrw),
        .wdata (din),
        .raddr (addrr),
        .rdata (arr_rdata_s)
    );

    assign rd_ok_s   = addr_ok(32'(addrr), unsigned'(DEPTH));
    assign wr_ok_s   = addr_ok(32'(addrw), unsigned'(DEPTH));
    assign collide_s = wen && ren && wr_ok_s && (addrw == addrr);

    // Next read data: hold when idle, zero when out of range, collision policy otherwise.
    always_comb begin
        dout_next_s = dout_r;
        if (ren) begin
            if (!rd_ok_s) begin
                dout_next_s = '0;
            end else if (collide_s) begin
`ifdef DUAL_PT_SRAM_BYPASS_EN
                dout_next_s = din;
`else
                dout_next_s = arr_rdata_s;
`endif
            end else begin
                dout_next_s = arr_rdata_s;
            end
        end else begin
            dout_next_s = dout_r;
        end
    end

    // Read output register; reset discards any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_r       <= '0;
            dout_valid_r <= 1'b0;
        end else begin
            dout_r       <= dout_next_s;
            dout_valid_r <= ren;
        end
    end

    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;

endmodule

// File: tb/tb_dual_pt_sram.sv
// Self-checking bench: a full-depth and a depth-8 instance share stimulus; a reference model feeds per-instance scoreboards.
module tb_dual_pt_sram;
    import dual_pt_sram_pkg::*;

`ifdef DUAL_PT_SRAM_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    data_t din = '0;
    logic  wen = 1'b0;
    logic  ren = 1'b0;
    addr_t addrw = '0;
    addr_t addrr = '0;
    data_t dout_a, dout_b;
    logic  vld_a, vld_b;

    int    checks = 0;
    int    errors = 0;
    data_t model [2][16];
    int    depth [2] = '{16, 8};
    data_t exp_q [2][$];
    data_t hold  [2];

    always #5 clk = ~clk;

    dual_pt_sram u_dut_a (
        .din(din), .wen(wen), .ren(ren), .clk(clk), .addrw(addrw), .addrr(addrr),
        .dout(dout_a), .rst_n(rst_n), .dout_valid(vld_a)
    );

    dual_pt_sram #(.DEPTH(8)) u_dut_b (
        .din(din), .wen(wen), .ren(ren), .clk(clk), .addrw(addrw), .addrr(addrr),
        .dout(dout_b), .rst_n(rst_n), .dout_valid(vld_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) model[k][i] = '0;
            exp_q[k].delete();
            hold[k] = '0;
        end
    endtask

    task automatic step(input string tag, input data_t d, input logic w, input logic r,
                        input addr_t aw, input addr_t ar);
        data_t e;
        data_t obs;
        logic  v;
        @(negedge clk);
        din = d; wen = w; ren = r; addrw = aw; addrr = ar;
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                if (int'(ar) >= depth[k])                          e = '0;
                else if (BYP && w && (aw == ar))                   e = d;
                else                                               e = model[k][ar];
                exp_q[k].push_back(e);
            end
            if (w && (int'(aw) < depth[k])) model[k][aw] = d;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            obs = (k == 0) ? dout_a : dout_b;
            v   = (k == 0) ? vld_a : vld_b;
            if (r) begin
                chk($sformatf("%s_valid%0d", tag, k), 32'(v), 32'd1);
                if (exp_q[k].size() == 0) begin
                    chk($sformatf("%s_queue%0d", tag, k), 32'd0, 32'd1);
                end else begin
                    e = exp_q[k].pop_front();
                    chk($sformatf("%s_dout%0d", tag, k), 32'(obs), 32'(e));
                    hold[k] = e;
                end
            end else begin
                chk($sformatf("%s_novalid%0d", tag, k), 32'(v), 32'd0);
                chk($sformatf("%s_hold%0d", tag, k), 32'(obs), 32'(hold[k]));
            end
        end
    endtask

    initial begin
        clear_model();
        // Write attempted during reset must be ignored.
        din = 8'd99; wen = 1'b1; addrw = 4'd3;
        #3;
        chk("rst_dout_a", 32'(dout_a), 32'd0);
        chk("rst_vld_a", 32'(vld_a), 32'd0);
        chk("rst_vld_b", 32'(vld_b), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        wen = 1'b0;
        rst_n = 1'b1;

        step("wr12", 8'd246, 1'b1, 1'b0, 4'd12, 4'd0);
        step("rd12", 8'd0, 1'b0, 1'b1, 4'd0, 4'd12);
        step("conc", 8'd200, 1'b1, 1'b1, 4'd11, 4'd12);
        step("rd11", 8'd0, 1'b0, 1'b1, 4'd0, 4'd11);
        step("wdis", 8'd200, 1'b0, 1'b0, 4'd0, 4'd0);
        step("rd0", 8'd0, 1'b0, 1'b1, 4'd0, 4'd0);
        step("rd3", 8'd0, 1'b0, 1'b1, 4'd0, 4'd3);
        step("wr5", 8'd77, 1'b1, 1'b0, 4'd5, 4'd0);
        step("rd5", 8'd0, 1'b0, 1'b1, 4'd0, 4'd5);
        step("coll", 8'd144, 1'b1, 1'b1, 4'd10, 4'd10);
        step("rd10", 8'd0, 1'b0, 1'b1, 4'd0, 4'd10);
        step("coll5", 8'd33, 1'b1, 1'b1, 4'd5, 4'd5);
        step("rd5b", 8'd0, 1'b0, 1'b1, 4'd0, 4'd5);
        step("wr9", 8'd88, 1'b1, 1'b0, 4'd9, 4'd0);
        step("rd9", 8'd0, 1'b0, 1'b1, 4'd0, 4'd9);
        step("rd12b", 8'd0, 1'b0, 1'b1, 4'd0, 4'd12);
        for (int i = 0; i < 3; i++) step("hold", 8'd55, 1'b1, 1'b0, 4'd2, 4'd0);

        // Reset asserted between edges clears outputs immediately.
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_dout_a", 32'(dout_a), 32'd0);
        chk("mrst_vld_a", 32'(vld_a), 32'd0);
        chk("mrst_dout_b", 32'(dout_b), 32'd0);
        clear_model();
        wen = 1'b0;
        ren = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step("post12", 8'd0, 1'b0, 1'b1, 4'd0, 4'd12);
        step("post5", 8'd0, 1'b0, 1'b1, 4'd0, 4'd5);
        step("post2", 8'd0, 1'b0, 1'b1, 4'd0, 4'd2);
        step("idle", 8'd0, 1'b0, 1'b0, 4'd0, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
